// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RV32I-style datapath (fetch, decode, memory, ALU, branch, jump).
// Optional JALR support is compiled in with `define MC_JALR_EN; without it opcode 1100111 decodes as illegal.
module multicycle_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7_b5_i,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output logic       pc_write_o,
   output logic       adr_src_o,
   output logic       mem_write_o,
   output logic       ir_write_o,
   output logic [1:0] result_src_o,
   output logic [1:0] alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [2:0] imm_src_o,
   output logic [3:0] alu_control_o,
   output logic       reg_write_o,
   output logic       illegal_o,
   output logic [3:0] state_o
);

   // state    | meaning
   // FETCH    | read instruction at PC, PC <= PC+4 once memory is ready
   // DECODE   | read registers, compute oldPC+imm (branch/jump target)
   // MEMADR   | compute load/store address rs1+imm
   // MEMREAD  | wait for load data
   // MEMWB    | write load data into rd
   // MEMWRITE | hold store strobe until memory is ready
   // EXECR    | R-type ALU operation
   // EXECI    | I-type ALU operation
   // ALUWB    | write ALU result into rd
   // JAL      | PC <= target, compute oldPC+4 for link
   // BRANCH   | compare rs1/rs2, conditionally load target
   // JALR     | PC <= rs1+imm
   // JALRLINK | compute oldPC+4 for link

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_BRANCH   = 4'd10,
      S_JALR     = 4'd11,
      S_JALRLINK = 4'd12
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   state_t     state_q;
   state_t     state_d;
   logic [1:0] alu_op;
   logic       pc_write_raw;
   logic       ir_write_raw;
   logic       mem_write_raw;
   logic       reg_write_raw;
   logic       illegal_raw;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      alu_op        = 2'b00;
      adr_src_o     = 1'b0;
      alu_src_a_o   = 2'b00;
      alu_src_b_o   = 2'b00;
      result_src_o  = 2'b00;
      pc_write_raw  = 1'b0;
      ir_write_raw  = 1'b0;
      mem_write_raw = 1'b0;
      reg_write_raw = 1'b0;
      illegal_raw   = 1'b0;
      case (state_q)
         S_FETCH: begin
            alu_src_b_o  = 2'b10;
            result_src_o = 2'b10;
            pc_write_raw = mem_ready_i;
            ir_write_raw = mem_ready_i;
            if (mem_ready_i) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b01;
            case (op_i)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_JAL:            state_d = S_JAL;
               OP_BR:             state_d = S_BRANCH;
`ifdef MC_JALR_EN
               OP_JALR:           state_d = S_JALR;
`endif
               default: begin
                  state_d     = S_FETCH;
                  illegal_raw = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a_o = 2'b10;
            alu_src_b_o = 2'b01;
            state_d     = op_i[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src_o = 1'b1;
            if (mem_ready_i) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src_o  = 2'b01;
            reg_write_raw = 1'b1;
            state_d       = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src_o     = 1'b1;
            mem_write_raw = 1'b1;
            if (mem_ready_i) state_d = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a_o = 2'b10;
            alu_op      = 2'b10;
            state_d     = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a_o = 2'b10;
            alu_src_b_o = 2'b01;
            alu_op      = 2'b10;
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_raw = 1'b1;
            state_d       = S_FETCH;
         end
         S_JAL: begin
            alu_src_a_o  = 2'b01;
            alu_src_b_o  = 2'b10;
            pc_write_raw = 1'b1;
            state_d      = S_ALUWB;
         end
         S_BRANCH: begin
            // funct3[0] distinguishes BNE from BEQ
            alu_src_a_o  = 2'b10;
            alu_op       = 2'b01;
            pc_write_raw = zero_i ^ funct3_i[0];
            state_d      = S_FETCH;
         end
`ifdef MC_JALR_EN
         S_JALR: begin
            alu_src_a_o  = 2'b10;
            alu_src_b_o  = 2'b01;
            result_src_o = 2'b10;
            pc_write_raw = 1'b1;
            state_d      = S_JALRLINK;
         end
         S_JALRLINK: begin
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b10;
            state_d     = S_ALUWB;
         end
`endif
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      case (op_i)
         OP_STORE: imm_src_o = 3'b001;
         OP_BR:    imm_src_o = 3'b010;
         OP_JAL:   imm_src_o = 3'b011;
         default:  imm_src_o = 3'b000;
      endcase
   end

   always_comb begin
      alu_control_o = 4'b0000;
      case (alu_op)
         2'b01: alu_control_o = 4'b0001;
         2'b10: begin
            case (funct3_i)
               3'b000:  alu_control_o = (funct7_b5_i & op_i[5]) ? 4'b0001 : 4'b0000;
               3'b001:  alu_control_o = 4'b0101;
               3'b010:  alu_control_o = 4'b0100;
               3'b100:  alu_control_o = 4'b0110;
               3'b101:  alu_control_o = funct7_b5_i ? 4'b1000 : 4'b0111;
               3'b110:  alu_control_o = 4'b0011;
               3'b111:  alu_control_o = 4'b0010;
               default: alu_control_o = 4'b0000;
            endcase
         end
         default: alu_control_o = 4'b0000;
      endcase
   end

   // strobes are forced low the whole time reset is high, not just after the edge
   assign pc_write_o  = pc_write_raw  & ~rst;
   assign ir_write_o  = ir_write_raw  & ~rst;
   assign mem_write_o = mem_write_raw & ~rst;
   assign reg_write_o = reg_write_raw & ~rst;
   assign illegal_o   = illegal_raw   & ~rst;
   assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction traces plus randomized inputs against a table-driven model.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op_i;
   logic [2:0] funct3_i;
   logic       funct7_b5_i;
   logic       zero_i;
   logic       mem_ready_i;
   logic       pc_write_o;
   logic       adr_src_o;
   logic       mem_write_o;
   logic       ir_write_o;
   logic [1:0] result_src_o;
   logic [1:0] alu_src_a_o;
   logic [1:0] alu_src_b_o;
   logic [2:0] imm_src_o;
   logic [3:0] alu_control_o;
   logic       reg_write_o;
   logic       illegal_o;
   logic [3:0] state_o;

`ifdef MC_JALR_EN
   localparam bit JEN = 1'b1;
`else
   localparam bit JEN = 1'b0;
`endif

   multicycle_controller dut (
      .clk(clk), .rst(rst), .op_i(op_i), .funct3_i(funct3_i), .funct7_b5_i(funct7_b5_i),
      .zero_i(zero_i), .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .adr_src_o(adr_src_o),
      .mem_write_o(mem_write_o), .ir_write_o(ir_write_o), .result_src_o(result_src_o),
      .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .imm_src_o(imm_src_o),
      .alu_control_o(alu_control_o), .reg_write_o(reg_write_o), .illegal_o(illegal_o),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   // Per-state static control fields: index = state number
   logic [1:0] t_a   [16];
   logic [1:0] t_b   [16];
   logic [1:0] t_rs  [16];
   logic [1:0] t_aop [16];
   logic       t_adr [16];
   logic       t_mw  [16];
   logic       t_rw  [16];

   initial begin
      for (int i = 0; i < 16; i++) begin
         t_a[i] = 2'd0; t_b[i] = 2'd0; t_rs[i] = 2'd0; t_aop[i] = 2'd0;
         t_adr[i] = 1'b0; t_mw[i] = 1'b0; t_rw[i] = 1'b0;
      end
      t_b[0] = 2; t_rs[0] = 2;
      t_a[1] = 1; t_b[1] = 1;
      t_a[2] = 2; t_b[2] = 1;
      t_adr[3] = 1;
      t_rs[4] = 1; t_rw[4] = 1;
      t_adr[5] = 1; t_mw[5] = 1;
      t_a[6] = 2; t_aop[6] = 2;
      t_a[7] = 2; t_b[7] = 1; t_aop[7] = 2;
      t_rw[8] = 1;
      t_a[9] = 1; t_b[9] = 2;
      t_a[10] = 2; t_aop[10] = 1;
      t_a[11] = 2; t_b[11] = 1; t_rs[11] = 2;
      t_a[12] = 1; t_b[12] = 2;
   end

   function automatic int dec_target(input logic [6:0] op);
      case (op)
         7'b0000011, 7'b0100011: return 2;
         7'b0110011: return 6;
         7'b0010011: return 7;
         7'b1101111: return 9;
         7'b1100011: return 10;
         7'b1100111: return JEN ? 11 : 0;
         default:    return 0;
      endcase
   endfunction

   function automatic bit is_legal(input logic [6:0] op);
      return dec_target(op) != 0;
   endfunction

   function automatic int mnext(input int s);
      case (s)
         0:  return mem_ready_i ? 1 : 0;
         1:  return dec_target(op_i);
         2:  return op_i[5] ? 5 : 3;
         3:  return mem_ready_i ? 4 : 3;
         5:  return mem_ready_i ? 0 : 5;
         6, 7, 9: return 8;
         11: return JEN ? 12 : 0;
         12: return JEN ? 8 : 0;
         default: return 0;
      endcase
   endfunction

   function automatic logic [3:0] exp_alu(input logic [1:0] aop);
      logic [3:0] f3tab [8];
      f3tab = '{4'd0, 4'd5, 4'd4, 4'd0, 4'd6, 4'd7, 4'd3, 4'd2};
      if (aop == 2'd1) return 4'd1;
      if (aop != 2'd2) return 4'd0;
      if (funct3_i == 3'd0) return (funct7_b5_i && op_i[5]) ? 4'd1 : 4'd0;
      if (funct3_i == 3'd5) return funct7_b5_i ? 4'd8 : 4'd7;
      return f3tab[funct3_i];
   endfunction

   function automatic logic [2:0] exp_imm(input logic [6:0] op);
      if (op == 7'b0100011) return 3'd1;
      if (op == 7'b1100011) return 3'd2;
      if (op == 7'b1101111) return 3'd3;
      return 3'd0;
   endfunction

   int ms = 0;
   bit mvalid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         ms     <= 0;
         mvalid <= 1'b1;
      end else if (mvalid) begin
         ms <= mnext(ms);
      end
   end

   always @(negedge clk) begin
      if (mvalid) begin
         logic pcw;
         pcw = (ms == 0 && mem_ready_i) || ms == 9 || (ms == 10 && (zero_i ^ funct3_i[0])) || ms == 11;
         chk("state",     32'(state_o),       32'(ms));
         chk("pc_write",  32'(pc_write_o),    32'(pcw && !rst));
         chk("ir_write",  32'(ir_write_o),    32'(ms == 0 && mem_ready_i && !rst));
         chk("mem_write", 32'(mem_write_o),   32'(t_mw[ms] && !rst));
         chk("reg_write", 32'(reg_write_o),   32'(t_rw[ms] && !rst));
         chk("illegal",   32'(illegal_o),     32'(ms == 1 && !is_legal(op_i) && !rst));
         chk("adr_src",   32'(adr_src_o),     32'(t_adr[ms]));
         chk("result_src",32'(result_src_o),  32'(t_rs[ms]));
         chk("alu_src_a", 32'(alu_src_a_o),   32'(t_a[ms]));
         chk("alu_src_b", 32'(alu_src_b_o),   32'(t_b[ms]));
         chk("alu_ctl",   32'(alu_control_o), 32'(exp_alu(t_aop[ms])));
         chk("imm_src",   32'(imm_src_o),     32'(exp_imm(op_i)));
      end
   end

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   // states: nibble i is the expected state in cycle i; rdy bit i is mem_ready_i in that cycle
   task automatic seq(input string name, input logic [31:0] states, input logic [7:0] rdy,
                      input int n, input bit ill, input logic [3:0] ctl6);
      for (int i = 0; i < n; i++) begin
         logic [3:0] e;
         e = states[i*4 +: 4];
         mem_ready_i = rdy[i];
         #1;
         chk({name, "_state"}, 32'(state_o),     32'(e));
         chk({name, "_regw"},  32'(reg_write_o), 32'(e == 4'd8 || e == 4'd4));
         chk({name, "_memw"},  32'(mem_write_o), 32'(e == 4'd5));
         chk({name, "_irw"},   32'(ir_write_o),  32'(e == 4'd0 && rdy[i]));
         chk({name, "_ill"},   32'(illegal_o),   32'(e == 4'd1 && ill));
         if (e == 4'd6) chk({name, "_ctl"}, 32'(alu_control_o), 32'(ctl6));
         if (e == 4'd4) chk({name, "_rsrc"}, 32'(result_src_o), 32'd1);
         adv();
      end
   endtask

   task automatic branch(input string name, input logic [2:0] f3, input logic z, input logic exp_pcw);
      op_i = 7'b1100011; funct3_i = f3; zero_i = z; mem_ready_i = 1'b1;
      adv();
      adv();
      mem_ready_i = 1'b0;
      #1;
      chk({name, "_state"}, 32'(state_o),    32'd10);
      chk({name, "_pcw"},   32'(pc_write_o), 32'(exp_pcw));
      adv();
      #1;
      chk({name, "_back"},  32'(state_o),    32'd0);
   endtask

   initial begin
      rst = 1'b1; op_i = '0; funct3_i = '0; funct7_b5_i = 1'b0; zero_i = 1'b0; mem_ready_i = 1'b0;
      adv();
      adv();
      mem_ready_i = 1'b1;
      #1;
      chk("rst_state", 32'(state_o),    32'd0);
      chk("rst_irw",   32'(ir_write_o), 32'd0);
      chk("rst_pcw",   32'(pc_write_o), 32'd0);
      rst = 1'b0;

      op_i = 7'b0110011; funct3_i = 3'd0; funct7_b5_i = 1'b0;
      seq("add", 32'h0000_8610, 8'h0F, 5, 1'b0, 4'd0);
      funct7_b5_i = 1'b1;
      seq("sub", 32'h0000_8610, 8'h0F, 5, 1'b0, 4'd1);
      funct3_i = 3'd5;
      seq("sra", 32'h0000_8610, 8'h0F, 5, 1'b0, 4'd8);

      op_i = 7'b0000011; funct3_i = 3'd2; funct7_b5_i = 1'b0;
      seq("lw", 32'h0433_3210, 8'h67, 8, 1'b0, 4'd0);

      op_i = 7'b0100011;
      seq("sw", 32'h0555_5210, 8'h47, 8, 1'b0, 4'd0);

      seq("sw_rst", 32'h0005_5210, 8'h07, 5, 1'b0, 4'd0);
      rst = 1'b1;
      #1;
      chk("sw_rst_memw", 32'(mem_write_o), 32'd0);
      chk("sw_rst_held", 32'(state_o),     32'd5);
      adv();
      rst = 1'b0;
      #1;
      chk("sw_rst_state", 32'(state_o),     32'd0);
      chk("sw_rst_memw2", 32'(mem_write_o), 32'd0);

      branch("bne_z0", 3'd1, 1'b0, 1'b1);
      branch("bne_z1", 3'd1, 1'b1, 1'b0);
      branch("beq_z0", 3'd0, 1'b0, 1'b0);
      branch("beq_z1", 3'd0, 1'b1, 1'b1);

      op_i = 7'b1100111;
      if (JEN) seq("jalr", 32'h0008_CB10, 8'h1F, 6, 1'b0, 4'd0);
      else     seq("jalr_ill", 32'h0000_0010, 8'h03, 3, 1'b1, 4'd0);

      op_i = 7'b1111111;
      seq("ill", 32'h0000_0010, 8'h03, 3, 1'b1, 4'd0);

      seq("stall", 32'h0000_0000, 8'h00, 5, 1'b0, 4'd0);

      for (int c = 0; c < 3000; c++) begin
         logic [6:0] ops [8];
         ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                 7'b1101111, 7'b1100011, 7'b1100111, 7'b0000000};
         ops[7]      = 7'($urandom);
         op_i        = ops[$urandom_range(0, 7)];
         funct3_i    = 3'($urandom);
         funct7_b5_i = 1'($urandom);
         zero_i      = 1'($urandom);
         mem_ready_i = ($urandom_range(0, 2) != 0);
         rst         = ($urandom_range(0, 59) == 0);
         adv();
      end

      rst = 1'b0;
      adv();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-002 SHALL have inputs: op_i 7 (IR opcode); funct3_i 3; funct7_b5_i 1; zero_i 1 (ALU zero flag); mem_ready_i 1 (memory access complete).
REQ-003 SHALL have outputs: pc_write_o 1; adr_src_o 1 (0=PC, 1=ALUOut); mem_write_o 1; ir_write_o 1; result_src_o 2 (00 ALUOut, 01 read data, 10 ALU result).
REQ-004 SHALL have outputs: alu_src_a_o 2 (00 PC, 01 oldPC, 10 rs1); alu_src_b_o 2 (00 rs2, 01 imm, 10 const 4); imm_src_o 3; alu_control_o 4; reg_write_o 1; illegal_o 1; state_o 4 (current state).

Function
REQ-005 SHALL be a Moore FSM, 4-bit state: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, JAL=9, BRANCH=10, JALR=11, JALRLINK=12.
REQ-006 Unlisted outputs in each state SHALL be 0; alu_control_o derives from an internal 2-bit alu_op (default 00).
REQ-007 FETCH: adr_src 0, a=00, b=10, alu_op 00, result_src 10; ir_write_o and pc_write_o = mem_ready_i; stay while mem_ready_i=0, else DECODE.
REQ-008 DECODE: a=01, b=01, alu_op 00; next by op_i: 0000011/0100011 MEMADR, 0110011 EXECR, 0010011 EXECI, 1101111 JAL, 1100011 BRANCH, 1100111 JALR; else FETCH with illegal_o=1 this cycle only.
REQ-009 MEMADR: a=10, b=01, add; next MEMREAD if op_i[5]=0 else MEMWRITE.
REQ-010 MEMREAD: adr_src 1, result_src 00; wait on mem_ready_i, then MEMWB. MEMWB: result_src 01, reg_write 1, then FETCH.
REQ-011 MEMWRITE: adr_src 1, result_src 00, mem_write_o 1 held every cycle until mem_ready_i=1, then FETCH.
REQ-012 EXECR: a=10, b=00, alu_op 10. EXECI: a=10, b=01, alu_op 10. Both then ALUWB. ALUWB: result_src 00, reg_write 1, then FETCH.
REQ-013 JAL: a=01, b=10, result_src 00, pc_write 1, then ALUWB (rd=oldPC+4, PC=target from DECODE).
REQ-014 BRANCH: a=10, b=00, alu_op 01, result_src 00; pc_write_o = zero_i XOR funct3_i[0] (BEQ/BNE); then FETCH.
REQ-015 JALR: a=10, b=01, add, result_src 10, pc_write 1, then JALRLINK; JALRLINK: a=01, b=10, add, then ALUWB.
REQ-016 imm_src_o combinational from op_i in all states: I-type/load/JALR 000, store 001, branch 010, JAL 011, other 000.
REQ-017 alu_control_o: alu_op 00 ADD 0000; 01 SUB 0001; 10 by funct3: 000 SUB if funct7_b5_i&op_i[5] else ADD; 001 SLL 0101; 010 SLT 0100; 100 XOR 0110; 101 SRA 1000 if funct7_b5_i else SRL 0111; 110 OR 0011; 111 AND 0010.
REQ-018 mem_ready_i is sampled only in FETCH, MEMREAD, MEMWRITE; ignored elsewhere.

Reset
REQ-019 rst=1 at a rising edge SHALL force state FETCH, overriding any transition, including mid-MEMWRITE or mid-wait.
REQ-020 While rst=1: pc_write_o, ir_write_o, mem_write_o, reg_write_o, illegal_o SHALL be 0; state_o=0 from the first edge after assertion.

Configuration
REQ-021 Macro MC_JALR_EN: defined, JALR/JALRLINK exist per REQ-015; undefined, opcode 1100111 is illegal (REQ-008) and state codes 11/12 are unreachable (fall back to FETCH).

Verification
REQ-022 ADD x3,x1,x2 (op 0110011, f3 000, f7b5 0), mem_ready_i=1 -> states 0,1,6,8,0; reg_write_o=1 only in ALUWB; alu_control_o=0000 in EXECR.
REQ-023 LW, mem_ready_i low 2 cycles in MEMREAD -> 0,1,2,3,3,3,4,0; result_src_o=01 in MEMWB.
REQ-024 SW with mem_ready_i=0 3 cycles in MEMWRITE -> mem_write_o=1 for 4 cycles, then FETCH; rst pulse during that window -> next state 0, mem_write_o=0.
REQ-025 BNE (f3 001), zero_i=0 -> pc_write_o=1 in BRANCH; zero_i=1 -> 0; BEQ opposite.
REQ-026 op 1100111 -> with MC_JALR_EN: 0,1,11,12,8,0; without: 0,1,0, illegal_o=1 one cycle.
REQ-027 FETCH with mem_ready_i=0 five cycles -> ir_write_o=0, pc_write_o=0 throughout, state held 0.
